// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline-control types and constants for the hazard/stall unit.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned PERF_W = 16;

    localparam logic [REG_W-1:0]  REG_ZERO = 5'd0;
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    typedef enum logic [1:0] {
        HZ_NONE  = 2'd0,
        HZ_LOAD  = 2'd1,
        HZ_MD    = 2'd2,
        HZ_FLUSH = 2'd3
    } hz_cause_e;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EX hazard inputs and pipeline-control outputs of the stall/flush controller.
interface hazard_stall_unit_if;
    import hazard_stall_unit_pkg::*;

    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_reads_hilo;
    logic              id_md_start;
    logic              id_ex_mem_read;
    logic [REG_W-1:0]  id_ex_rt;
    logic              ex_branch_taken;
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo, id_md_start,
               id_ex_mem_read, id_ex_rt, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo, id_md_start,
               id_ex_mem_read, id_ex_rt, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy, stall_cnt
    );

endinterface

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Mult/div busy counter: load, decrement, and flag the final busy cycle (count == 1).
module md_busy_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use and mult/div interlocks plus branch flush for the 5-stage pipe.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_unit_if.slave   hz
);

    md_state_e         state_q, state_d;
    logic              md_busy_q, md_busy_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic      load_use_c;
    logic      md_hazard_c;
    logic      stall_c;
    logic      md_load_c;
    logic      md_dec_c;
    logic      md_last_c;
    hz_cause_e cause_c;

    // Busy period lasts MD_CYCLES-1 cycles so MFHI/MFLO issued MD_CYCLES after the start proceeds.
    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (md_load_c),
        .load_val (CNT_W'(MD_CYCLES - 1)),
        .dec      (md_dec_c),
        .last_c   (md_last_c)
    );

    always_comb begin
        load_use_c  = hz.id_ex_mem_read && (hz.id_ex_rt != REG_ZERO) &&
                      ((hz.id_uses_rs && (hz.id_rs == hz.id_ex_rt)) ||
                       (hz.id_uses_rt && (hz.id_rt == hz.id_ex_rt)));
        md_hazard_c = md_busy_q && (hz.id_reads_hilo || hz.id_md_start);
        stall_c     = (load_use_c || md_hazard_c) && !hz.ex_branch_taken;

        if (hz.ex_branch_taken) begin
            cause_c = HZ_FLUSH;
        end else if (load_use_c) begin
            cause_c = HZ_LOAD;
        end else if (md_hazard_c) begin
            cause_c = HZ_MD;
        end else begin
            cause_c = HZ_NONE;
        end

        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        case (cause_c)
            HZ_FLUSH: begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end
            HZ_LOAD, HZ_MD: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // Mult/div tracking; an in-flight operation is never cancelled by a branch.
    always_comb begin
        state_d   = state_q;
        md_load_c = 1'b0;
        md_dec_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.id_md_start && !stall_c && !hz.ex_branch_taken) begin
                    md_load_c = 1'b1;
                    state_d   = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                md_dec_c = 1'b1;
                if (md_last_c) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        md_busy_d = (state_d == ST_MD_WAIT);

        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != PERF_MAX)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            md_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_busy_q   <= md_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.md_busy   = md_busy_q;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, $zero, mult/div interlock, branch priority, reset.
module tb_hazard_stall_unit;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   cycles;

    hazard_stall_unit_if hz ();

    hazard_stall_unit #(
        .MD_CYCLES (32),
        .CNT_W     (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.id_rs           = 5'd0;
        hz.id_rt           = 5'd0;
        hz.id_uses_rs      = 1'b0;
        hz.id_uses_rt      = 1'b0;
        hz.id_reads_hilo   = 1'b0;
        hz.id_md_start     = 1'b0;
        hz.id_ex_mem_read  = 1'b0;
        hz.id_ex_rt        = 5'd0;
        hz.ex_branch_taken = 1'b0;
    endtask

    // Advance to 1 ns after the next rising edge; checks happen at +5 (falling edge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic pw, input logic iw,
                              input logic fl, input logic bb);
        check({tag, ".pc_write"},     32'(hz.pc_write),     32'(pw));
        check({tag, ".if_id_write"},  32'(hz.if_id_write),  32'(iw));
        check({tag, ".if_id_flush"},  32'(hz.if_id_flush),  32'(fl));
        check({tag, ".id_ex_bubble"}, 32'(hz.id_ex_bubble), 32'(bb));
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        idle();
        rst_n = 1'b0;
        #12;
        check_ctrl("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset.md_busy",   32'(hz.md_busy),   32'd0);
        check("reset.stall_cnt", 32'(hz.stall_cnt), 32'd0);
        #5 rst_n = 1'b1;
        next_cycle();

        // Load-use on rs: one stall cycle, released once the load leaves EX.
        hz.id_ex_mem_read = 1'b1; hz.id_ex_rt = 5'd8;
        hz.id_rs = 5'd8; hz.id_rt = 5'd10; hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
        #4 check_ctrl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        hz.id_ex_mem_read = 1'b0;
        #4 check_ctrl("lu_rs_rel", 1'b1, 1'b1, 1'b0, 1'b0);
        check("lu_rs_rel.stall_cnt", 32'(hz.stall_cnt), 32'd1);
        next_cycle();

        // Load-use on rt only.
        idle();
        hz.id_ex_mem_read = 1'b1; hz.id_ex_rt = 5'd9;
        hz.id_rs = 5'd3; hz.id_rt = 5'd9; hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
        #4 check_ctrl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        // Matching rt that is not read must not stall.
        hz.id_uses_rt = 1'b0;
        #4 check_ctrl("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
        check("lu_rt.stall_cnt", 32'(hz.stall_cnt), 32'd2);
        next_cycle();

        // Load to $zero never stalls.
        idle();
        hz.id_ex_mem_read = 1'b1; hz.id_ex_rt = 5'd0;
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b1; hz.id_uses_rt = 1'b1;
        #4 check_ctrl("lu_zero", 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();

        // Branch beats load-use: flush, no stall counted.
        idle();
        hz.id_ex_mem_read = 1'b1; hz.id_ex_rt = 5'd8;
        hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1; hz.ex_branch_taken = 1'b1;
        #4 check_ctrl("br_lu", 1'b1, 1'b1, 1'b1, 1'b1);
        next_cycle();
        idle();
        #4 check("br_lu.stall_cnt", 32'(hz.stall_cnt), 32'd2);
        next_cycle();

        // MULT then MFLO: MFLO held for 31 cycles.
        hz.id_md_start = 1'b1;
        #4 check_ctrl("mult_issue", 1'b1, 1'b1, 1'b0, 1'b0);
        check("mult_issue.md_busy", 32'(hz.md_busy), 32'd0);
        next_cycle();
        hz.id_md_start = 1'b0; hz.id_reads_hilo = 1'b1;
        cycles = 0;
        #4;
        while (hz.pc_write == 1'b0 && cycles < 100) begin
            cycles++;
            next_cycle();
            #4;
        end
        check("mflo.stall_cycles", 32'(cycles), 32'd31);
        check("mflo.md_busy", 32'(hz.md_busy), 32'd0);
        check("mflo.stall_cnt", 32'(hz.stall_cnt), 32'd33);
        next_cycle();

        // Back-to-back DIV: second held until RUN, then busy again; a branch does not cancel it.
        idle();
        hz.id_md_start = 1'b1;
        next_cycle();
        cycles = 0;
        #4;
        while (hz.pc_write == 1'b0 && cycles < 100) begin
            cycles++;
            next_cycle();
            #4;
        end
        check("div2.held_cycles", 32'(cycles), 32'd31);
        check("div2.accept_busy", 32'(hz.md_busy), 32'd0);
        next_cycle();
        hz.id_md_start = 1'b0;
        cycles = 0;
        #4;
        while (hz.md_busy == 1'b1 && cycles < 100) begin
            cycles++;
            hz.ex_branch_taken = (cycles == 3);
            next_cycle();
            #4;
        end
        hz.ex_branch_taken = 1'b0;
        check("div2.busy_cycles", 32'(cycles), 32'd31);
        check("div2.stall_cnt", 32'(hz.stall_cnt), 32'd64);
        next_cycle();

        // Mult/div with simultaneous load-use is not accepted; retried next cycle.
        idle();
        hz.id_md_start = 1'b1; hz.id_ex_mem_read = 1'b1; hz.id_ex_rt = 5'd4;
        hz.id_rs = 5'd4; hz.id_uses_rs = 1'b1;
        #4 check_ctrl("md_lu", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        hz.id_ex_mem_read = 1'b0;
        #4 check("md_lu.not_accepted", 32'(hz.md_busy), 32'd0);
        next_cycle();
        idle();
        #4 check("md_lu.retry_busy", 32'(hz.md_busy), 32'd1);
        check("md_lu.stall_cnt", 32'(hz.stall_cnt), 32'd65);
        cycles = 0;
        while (hz.md_busy == 1'b1 && cycles < 100) begin
            cycles++;
            next_cycle();
            #4;
        end
        check("md_lu.busy_cycles", 32'(cycles), 32'd31);
        next_cycle();

        // Reset in the middle of a busy period (counter at 10).
        hz.id_md_start = 1'b1;
        next_cycle();
        hz.id_md_start = 1'b0;
        repeat (21) next_cycle();
        hz.id_reads_hilo = 1'b1;
        #1 check("rst_mid.busy_before", 32'(hz.md_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.md_busy",   32'(hz.md_busy),   32'd0);
        check("rst_mid.stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check_ctrl("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        next_cycle();
        #4 check_ctrl("rst_mid_run", 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_mid_run.md_busy", 32'(hz.md_busy), 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
